// File: rtl/rr_arb8_if.sv
`default_nettype none
// =============================================================================
// Module      : rr_arb8_if
// Description : Request/grant bundle between eight requesters and rr_arb8.
// Revision    : 1.0 - initial release
// =============================================================================
interface rr_arb8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       timeout;
    logic [2:0] ptr;

    // Requester side: raises requests and signals release.
    modport master (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  valid,
        input  timeout,
        input  ptr
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output sel,
        output valid,
        output timeout,
        output ptr
    );
endinterface
`default_nettype wire

// File: rtl/rr_arb8.sv
`default_nettype none
// =============================================================================
// Module      : rr_arb8
// Description : Round-robin arbiter for an 8:1 mux; registered one-hot grant,
//               binary select, valid, and MAXHOLD-bounded hold time.
//               Optional: define ARB8_HIPRI_EN to make requester 0 high priority.
// Revision    : 1.0 - initial release
// =============================================================================
module rr_arb8 #(
    parameter int MAXHOLD = 16,
    parameter int CW      = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    rr_arb8_if.slave  bus
);

    localparam logic [0:0]    c_idle     = 1'b0;
    localparam logic [0:0]    c_grant    = 1'b1;
    localparam logic [CW-1:0] c_last_cnt = CW'(MAXHOLD - 1);

    logic [0:0]    r_state;
    logic [7:0]    r_gnt;
    logic [2:0]    r_sel;
    logic          r_valid;
    logic          r_timeout;
    logic [2:0]    r_ptr;
    logic [CW-1:0] r_cnt;

    logic [7:0]    w_rot;
    logic [2:0]    w_off;
    logic [2:0]    w_win;
    logic          w_withdraw;
    logic          w_expire;
    logic          w_release;
    logic          w_forced;

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        w_rot = 8'({bus.req, bus.req} >> r_ptr);
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
        w_win = r_ptr + w_off;
`ifdef ARB8_HIPRI_EN
        if (bus.req[0]) begin
            w_win = 3'd0;
        end
`endif
    end

    always_comb begin
        w_withdraw = ~bus.req[r_sel];
        w_expire   = (r_cnt == c_last_cnt);
        w_release  = bus.done | w_withdraw | w_expire;
        w_forced   = w_expire & ~bus.done & ~w_withdraw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_gnt     <= 8'd0;
            r_sel     <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= 3'd0;
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (|bus.req) begin
                        r_gnt   <= 8'd1 << w_win;
                        r_sel   <= w_win;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_grant;
                    end
                end
                c_grant: begin
                    if (w_release) begin
                        r_gnt     <= 8'd0;
                        r_valid   <= 1'b0;
                        r_timeout <= w_forced;
                        r_state   <= c_idle;
`ifdef ARB8_HIPRI_EN
                        // A channel-0 grant leaves the low-priority rotation untouched.
                        if (r_sel != 3'd0) begin
                            r_ptr <= r_sel + 3'd1;
                        end
`else
                        r_ptr <= r_sel + 3'd1;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.sel     = r_sel;
    assign bus.valid   = r_valid;
    assign bus.timeout = r_timeout;
    assign bus.ptr     = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// =============================================================================
// Module      : tb_rr_arb8
// Description : Self-checking bench for rr_arb8 (MAXHOLD=4); honours ARB8_HIPRI_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_rr_arb8;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       tmo;
        logic [2:0] ptr;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       tmo;
        logic [2:0] ptr;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    vec_t tbl[$];

    rr_arb8_if u_bus ();

    rr_arb8 #(
        .MAXHOLD (4),
        .CW      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic d,
                                input logic [7:0] g, input logic [2:0] s, input logic v,
                                input logic t, input logic [2:0] p);
        vec_t x;
        x.rst = r; x.req = rq; x.done = d;
        x.gnt = g; x.sel = s; x.valid = v; x.tmo = t; x.ptr = p;
        return x;
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if ({u_bus.gnt, u_bus.sel, u_bus.valid, u_bus.timeout, u_bus.ptr} !==
            {e.gnt, e.sel, e.valid, e.tmo, e.ptr}) begin
            n_fail++;
            $display("FAIL %s: got gnt=%h sel=%0d valid=%b timeout=%b ptr=%0d, expected gnt=%h sel=%0d valid=%b timeout=%b ptr=%0d",
                     e.tag, u_bus.gnt, u_bus.sel, u_bus.valid, u_bus.timeout, u_bus.ptr,
                     e.gnt, e.sel, e.valid, e.tmo, e.ptr);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        rst         = v.rst;
        u_bus.req   = v.req;
        u_bus.done  = v.done;
        e.gnt = v.gnt; e.sel = v.sel; e.valid = v.valid; e.tmo = v.tmo; e.ptr = v.ptr;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        u_bus.req  = 8'h00;
        u_bus.done = 1'b0;

        // Reset and idle
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0));
`ifndef ARB8_HIPRI_EN
        // req=81, done three cycles into each grant: ch0, ch7, ch0 with 7->0 wrap
        tbl.push_back(mk(0, 8'h81, 0, 8'h01, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h81, 0, 8'h01, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h81, 0, 8'h01, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h81, 1, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h81, 0, 8'h80, 7, 1, 0, 1));
        tbl.push_back(mk(0, 8'h81, 0, 8'h80, 7, 1, 0, 1));
        tbl.push_back(mk(0, 8'h81, 0, 8'h80, 7, 1, 0, 1));
        tbl.push_back(mk(0, 8'h81, 1, 8'h00, 7, 0, 0, 0));
        tbl.push_back(mk(0, 8'h81, 0, 8'h01, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h81, 1, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
`endif
        foreach (tbl[i]) step(tbl[i], $sformatf("table[%0d]", i));

`ifndef ARB8_HIPRI_EN
        // All requesting, never releasing: 4-cycle grants, timeout pulse, sel 0..7,0
        step(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0), "tmo_reset");
        for (int g = 0; g < 9; g++) begin
            logic [2:0] s;
            s = 3'(g % 8);
            for (int c = 0; c < 4; c++)
                step(mk(0, 8'hFF, 0, 8'h01 << s, s, 1, 0, s), $sformatf("tmo_g%0d_c%0d", g, c));
            step(mk(0, 8'hFF, 0, 8'h00, s, 0, 1, s + 3'd1), $sformatf("tmo_g%0d_rel", g));
        end
        step(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 1), "tmo_idle");
`endif

        // Withdrawal of ch3 during its grant
        step(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0), "wd_reset");
        step(mk(0, 8'h08, 0, 8'h08, 3, 1, 0, 0), "wd_grant");
        step(mk(0, 8'h08, 0, 8'h08, 3, 1, 0, 0), "wd_hold");
        step(mk(0, 8'h00, 0, 8'h00, 3, 0, 0, 4), "wd_release");
        step(mk(0, 8'h00, 0, 8'h00, 3, 0, 0, 4), "wd_idle");

        // done coinciding with the final allowed cycle suppresses timeout
        step(mk(0, 8'h10, 0, 8'h10, 4, 1, 0, 4), "dl_grant");
        step(mk(0, 8'h10, 0, 8'h10, 4, 1, 0, 4), "dl_c1");
        step(mk(0, 8'h10, 0, 8'h10, 4, 1, 0, 4), "dl_c2");
        step(mk(0, 8'h10, 0, 8'h10, 4, 1, 0, 4), "dl_c3");
        step(mk(0, 8'h10, 1, 8'h00, 4, 0, 0, 5), "dl_release");

        // Reset mid-grant on ch5
        step(mk(0, 8'h20, 0, 8'h20, 5, 1, 0, 5), "rm_grant");
        step(mk(0, 8'h20, 0, 8'h20, 5, 1, 0, 5), "rm_hold");
        step(mk(1, 8'h20, 0, 8'h00, 0, 0, 0, 0), "rm_reset");
        step(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0), "rm_after");

        // Reset on the edge where a timeout would have fired
        step(mk(0, 8'h20, 0, 8'h20, 5, 1, 0, 0), "rt_grant");
        step(mk(0, 8'h20, 0, 8'h20, 5, 1, 0, 0), "rt_c1");
        step(mk(0, 8'h20, 0, 8'h20, 5, 1, 0, 0), "rt_c2");
        step(mk(0, 8'h20, 0, 8'h20, 5, 1, 0, 0), "rt_c3");
        step(mk(1, 8'h20, 0, 8'h00, 0, 0, 0, 0), "rt_reset");
        step(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0), "rt_after");

        // Bring ptr to 4, then request ch0 and ch4 together
        step(mk(0, 8'h08, 0, 8'h08, 3, 1, 0, 0), "pp_grant3");
        step(mk(0, 8'h08, 1, 8'h00, 3, 0, 0, 4), "pp_release3");
`ifdef ARB8_HIPRI_EN
        step(mk(0, 8'h11, 0, 8'h01, 0, 1, 0, 4), "hp_grant0");
        step(mk(0, 8'h11, 1, 8'h00, 0, 0, 0, 4), "hp_release0");
        step(mk(0, 8'h10, 0, 8'h10, 4, 1, 0, 4), "hp_grant4");
        step(mk(0, 8'h10, 1, 8'h00, 4, 0, 0, 5), "hp_release4");
`else
        step(mk(0, 8'h11, 0, 8'h10, 4, 1, 0, 4), "rr_grant4");
        step(mk(0, 8'h11, 1, 8'h00, 4, 0, 0, 5), "rr_release4");
        step(mk(0, 8'h11, 0, 8'h01, 0, 1, 0, 5), "rr_grant0");
        step(mk(0, 8'h11, 1, 8'h00, 0, 0, 0, 1), "rr_release0");
`endif

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
